i_cache_loader: RTL and testbench

// - Write-side companion to the instruction memory: fills it at boot from an 8-bit valid/ready byte stream.
// - Assembles little-endian 32-bit words and drives the memory write port.
// - Holds the core in reset (core_rst_n low) until the image is loaded.
// - Sits between the boot/debug byte source and the instruction memory write port.

---
 rtl/i_cache_loader.sv | 176 +++++++++++++++++
 tb/tb_i_cache_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache_loader.sv
// -----------------------------------------------------------------------------
// i_cache_loader
//
// Boot-time filler for the instruction memory. Receives an 8-bit valid/ready
// byte stream, assembles little-endian 32-bit words and drives the memory
// write port. The core is held in reset (core_rst_n low) until the image has
// been loaded.
//
// Stream format: LEN_LO, LEN_HI (16-bit word count), 4*LEN payload bytes,
// then one checksum byte when I_CACHE_LOADER_CHECKSUM_EN is defined.
//
// Optional feature macro: I_CACHE_LOADER_CHECKSUM_EN
//   defined     -> CHK state compares a trailing byte against the XOR of all
//                  payload bytes; mismatch ends in ERR (words stay written).
//   not defined -> no CHK state; err only for len > MaxWords.
//
// Handshake: a byte transfers on a rising edge where s_valid & s_ready are
// both high. s_ready depends only on the FSM state, never on s_valid.
//
// Ports
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   start       in   1    begins a load; honoured in IDLE, DONE, ERR only
//   s_data      in   8    stream byte
//   s_valid     in   1    stream byte valid
//   s_ready     out  1    loader accepts a byte (LEN0..CHK)
//   mem_we      out  1    one-cycle word write strobe
//   mem_waddr   out  DPW  word byte address (BaseAddr + 4*word_idx)
//   mem_wdata   out  DPW  assembled word, byte k at bits [8k+7:8k]
//   busy        out  1    load in progress
//   done        out  1    image loaded, held until next start
//   err         out  1    load failed, held until next start
//   core_rst_n  out  1    core reset, high only in DONE
// -----------------------------------------------------------------------------
module i_cache_loader #(
    parameter int             DPW      = 32,
    parameter int             Depth    = 32,
    parameter logic [DPW-1:0] BaseAddr = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [7:0]     s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic           mem_we,
    output logic [DPW-1:0] mem_waddr,
    output logic [DPW-1:0] mem_wdata,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           core_rst_n
);

    localparam int MaxWords = Depth / 4;
    localparam int WIW      = $clog2(MaxWords + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN0 = 3'd1;
    localparam logic [2:0] S_LEN1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

`ifdef I_CACHE_LOADER_CHECKSUM_EN
    // Payload end leads to the checksum byte.
    localparam logic [2:0] S_AFTER = S_CHK;
`else
    localparam logic [2:0] S_AFTER = S_DONE;
`endif

    logic [2:0]     state;
    logic [15:0]    len;
    logic [1:0]     byte_cnt;
    logic [WIW-1:0] word_idx;
    logic [23:0]    word_buf;   // lower three bytes of the word being built
    logic           xfer;
    logic [15:0]    len_full;
    logic           last_word;
`ifdef I_CACHE_LOADER_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    assign s_ready    = (state == S_LEN0) || (state == S_LEN1) ||
                        (state == S_DATA) || (state == S_CHK);
    assign busy       = s_ready;
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);
    assign core_rst_n = (state == S_DONE);

    assign xfer      = s_valid && s_ready;
    assign len_full  = {s_data, len[7:0]};
    // len is known nonzero and <= MaxWords whenever DATA is active.
    assign last_word = (16'(word_idx) == (len - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            byte_cnt  <= '0;
            word_idx  <= '0;
            word_buf  <= '0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
`ifdef I_CACHE_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN0;
                        byte_cnt <= '0;
                        word_idx <= '0;
                        word_buf <= '0;
`ifdef I_CACHE_LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        len[7:0] <= s_data;
                        state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        len[15:8] <= s_data;
                        if (len_full > 16'(MaxWords)) begin
                            state <= S_ERR;
                        end else if (len_full == 16'd0) begin
                            state <= S_AFTER;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef I_CACHE_LOADER_CHECKSUM_EN
                        csum <= csum ^ s_data;
`endif
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Fourth byte goes straight into the write data,
                            // so the strobe lands on the very next cycle.
                            mem_we    <= 1'b1;
                            mem_wdata <= DPW'({s_data, word_buf});
                            mem_waddr <= BaseAddr + DPW'({word_idx, 2'b00});
                            word_idx  <= word_idx + {{(WIW-1){1'b0}}, 1'b1};
                            word_buf  <= '0;
                            if (last_word) begin
                                state <= S_AFTER;
                            end
                        end else begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= s_data;
                        end
                    end
                end
`ifdef I_CACHE_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        state <= (s_data == csum) ? S_DONE : S_ERR;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache_loader.sv
// -----------------------------------------------------------------------------
// tb_i_cache_loader
//
// Directed bench for i_cache_loader. Expected memory writes ({addr,data}) are
// pushed into exp_q as the stream is driven; a negedge monitor pops and
// compares them whenever mem_we is seen. Status outputs are compared at
// fixed points of the sequence.
// -----------------------------------------------------------------------------
module tb_i_cache_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_rst_n;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    logic [63:0] exp_q[$];

    i_cache_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_rst_n (core_rst_n)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- comparison ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_waddr, mem_wdata}, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                chk("mem_write", {mem_waddr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive one byte after 'gap' idle cycles; returns 1 ns after the
    // handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
            chk("ready_in_gap", {63'd0, s_ready}, 64'd1);
            @(posedge clk); #1;
        end
        s_data  = b;
        s_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("handshake_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] c, input int gap);
`ifdef I_CACHE_LOADER_CHECKSUM_EN
        send_byte(c, gap);
`else
        if (c == 8'hFF && gap < 0) $display("unused");
`endif
    endtask

    // Sends header + payload and queues the expected writes.
    task automatic send_image(input logic [7:0] bytes[], input int gap);
        int nwords;
        nwords = {bytes[1], bytes[0]};
        for (int w = 0; w < nwords; w++) begin
            exp_q.push_back({32'(w * 4), bytes[2+4*w+3], bytes[2+4*w+2],
                             bytes[2+4*w+1], bytes[2+4*w]});
        end
        foreach (bytes[i]) send_byte(bytes[i], gap);
    endtask

    // Wait for done or err, then compare final status and write count.
    task automatic wait_end(input string tag, input logic exp_done, input int exp_writes);
        int t;
        t = 0;
        @(negedge clk);
        while (done !== 1'b1 && err !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk({tag, "_timeout"}, 64'd0, 64'd1);
        chk({tag, "_done"},       {63'd0, done},       {63'd0, exp_done});
        chk({tag, "_err"},        {63'd0, err},        {63'd0, ~exp_done});
        chk({tag, "_core_rst_n"}, {63'd0, core_rst_n}, {63'd0, exp_done});
        chk({tag, "_busy"},       {63'd0, busy},       64'd0);
        @(negedge clk); #1;
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_writes"},      64'(wr_cnt),        64'(exp_writes));
        exp_q.delete();
        wr_cnt = 0;
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] img2[];
    logic [7:0] img1[];
    logic [7:0] hdr[];

    initial begin
        img2 = '{8'h02, 8'h00, 8'h03, 8'h22, 8'h02, 8'h00, 8'h83, 8'hA2, 8'h42, 8'h00};
        img1 = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        rst_n   = 1'b0;
        start   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_outputs", {mem_we, s_ready, busy, done, err, core_rst_n}, 64'd0);
        chk("rst_addr_data", {mem_waddr, mem_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", {63'd0, s_ready}, 64'd0);

        // 2-word load, continuous s_valid
        pulse_start();
        chk("len0_busy", {62'd0, busy, core_rst_n}, 64'd2);
        send_image(img2, 0);
        send_csum(8'h40, 0);
        wait_end("load2", 1'b1, 2);

        // Bytes offered in DONE are not consumed
        s_data  = 8'h55;
        s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("done_no_ready", {62'd0, s_ready, done}, 64'd1);
        end
        s_valid = 1'b0;

        // Same stream with 3-cycle gaps; a start pulse mid-load is ignored
        pulse_start();
        chk("restart_core_rst", {62'd0, core_rst_n, done}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(64'h0000_0000_0002_2203);
            exp_q.push_back(64'h0000_0004_0042_A283);
            break;
        end
        for (int i = 0; i < 10; i++) begin
            send_byte(img2[i], 3);
            if (i == 5) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("start_ignored_busy", {63'd0, busy}, 64'd1);
            end
        end
        send_csum(8'h40, 3);
        wait_end("load2_gap", 1'b1, 2);

        // len = 0
        pulse_start();
        hdr = '{8'h00, 8'h00};
        send_image(hdr, 0);
`ifdef I_CACHE_LOADER_CHECKSUM_EN
        send_csum(8'h00, 0);
`endif
        @(negedge clk);
        chk("len0_done_next", {62'd0, done, busy}, 64'd2);
        wait_end("len_zero", 1'b1, 0);

        // len > MaxWords -> ERR, then recovery
        pulse_start();
        hdr = '{8'h09, 8'h00};
        send_image(hdr, 0);
        exp_q.delete();
        @(negedge clk);
        chk("oversize_err", {61'd0, err, core_rst_n, done}, 64'd4);
        wait_end("oversize", 1'b0, 0);
        pulse_start();
        chk("err_cleared", {63'd0, err}, 64'd0);
        send_image(img1, 1);
        send_csum(8'h44, 0);
        wait_end("recover", 1'b1, 1);

        // Reset in the middle of word 0
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {mem_we, s_ready, busy, done, err, core_rst_n}, 64'd0);
        chk("async_rst_addr_data", {mem_waddr, mem_wdata}, 64'd0);
        repeat (3) @(negedge clk);
        chk("held_rst_no_write", 64'(wr_cnt), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        send_image(img1, 0);
        send_csum(8'h44, 0);
        wait_end("after_reset", 1'b1, 1);

`ifdef I_CACHE_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        hdr = '{8'h01, 8'h00, 8'h03, 8'h22, 8'h02, 8'h00};
        send_image(hdr, 0);
        send_byte(8'h23, 0);
        wait_end("csum_ok", 1'b1, 1);
        pulse_start();
        send_image(hdr, 0);
        send_byte(8'h24, 0);
        wait_end("csum_bad", 1'b0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
